// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions: opcode constants, fetch FSM state encoding and
// the default address width used by the fetch stage.
package riscv_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_RUN   = 2'd1,
        FS_FLUSH = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO for fetched {pc, instr} entries. The head entry is
// read straight from the storage array so a word pushed on one edge is
// visible at the output right after it. clear wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    input  logic                       clear,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push, do_pop;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];
    assign do_pop    = pop && !empty;
    assign do_push   = push && (!full || do_pop);

    // Storage write; entries need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= (wr_ptr_reg == LAST_PTR) ? '0 : wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= (rd_ptr_reg == LAST_PTR) ? '0 : rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to
// instruction memory, buffers in-order responses and hands {pc, instr, opcode}
// to decode. Redirects retarget the PC, flush the buffer and drop responses to
// requests already in flight.
// Optional build macro INSTR_FETCH_ALIGN_CHECK_EN: a misaligned redirect raises
// a sticky if_misaligned flag and halts fetch until an aligned redirect.
module instr_fetch_unit #(
    parameter int              XLEN       = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    output logic            if_misaligned,
`endif
    output logic [6:0]      if_opcode
);

    import riscv_pkg::*;

    localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int ENTRY_W = XLEN + 32;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    fetch_state_e     state_reg, state_next;
    logic [XLEN-1:0]  pc_reg, pc_next;
    logic [XLEN-1:0]  resp_pc_reg, resp_pc_next;   // address of the next response kept
    logic [CNT_W-1:0] outstanding_reg, outstanding_next;
    logic [CNT_W-1:0] drop_cnt_reg, drop_cnt_next;
    logic             hold_reg, hold_next;         // request shown but not yet accepted

    logic             halted;
    logic             redirect_take, accept, rsp_ok, keep_rsp, pop, credit_ok;
    logic [CNT_W:0]   credit_used;
    logic [XLEN-1:0]  redirect_target;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty, fifo_full;
    logic [ENTRY_W-1:0] fifo_head;

`ifdef INSTR_FETCH_ALIGN_CHECK_EN
    logic misaligned_reg, misaligned_next;
    assign halted        = misaligned_reg;
    assign if_misaligned = misaligned_reg;
`else
    assign halted = 1'b0;
`endif

    // A slot freed by this cycle's pop counts as a credit so that steady-state
    // fetch sustains one word per cycle; a shown request stays up until taken.
    assign redirect_take   = redirect_valid && (state_reg != FS_IDLE);
    assign redirect_target = redirect_pc & ALIGN_MASK;
    assign pop             = if_valid && if_ready;
    assign credit_used     = {1'b0, outstanding_reg} + {1'b0, fifo_count} - {{CNT_W{1'b0}}, pop};
    assign credit_ok       = credit_used < (CNT_W + 1)'(FIFO_DEPTH);
    assign imem_req_valid  = (state_reg == FS_RUN) && !halted && (credit_ok || hold_reg);
    assign imem_req_addr   = pc_reg;
    assign accept          = imem_req_valid && imem_req_ready;
    assign rsp_ok          = imem_rsp_valid && (outstanding_reg != '0);
    assign keep_rsp        = rsp_ok && (state_reg == FS_RUN) && !redirect_take && !halted
                             && (!fifo_full || pop);

    assign if_valid  = !fifo_empty;
    assign if_pc     = fifo_head[ENTRY_W-1:32];
    assign if_instr  = fifo_head[31:0];
    assign if_opcode = fifo_head[6:0];

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (keep_rsp),
        .push_data ({resp_pc_reg, imem_rsp_data}),
        .pop       (pop),
        .clear     (redirect_take),
        .head_data (fifo_head),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Next-state logic: PC advance, credit/drop counters and FSM, redirect last.
    always_comb begin
        state_next       = state_reg;
        pc_next          = pc_reg;
        resp_pc_next     = resp_pc_reg;
        drop_cnt_next    = drop_cnt_reg;
        hold_next        = imem_req_valid && !imem_req_ready && !redirect_take;
        outstanding_next = outstanding_reg + CNT_W'(accept) - CNT_W'(rsp_ok);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        misaligned_next  = misaligned_reg;
`endif
        if (accept) begin
            pc_next = pc_reg + PC_STEP;
        end
        if (keep_rsp) begin
            resp_pc_next = resp_pc_reg + PC_STEP;
        end
        case (state_reg)
            FS_IDLE: state_next = FS_RUN;
            FS_RUN:  state_next = FS_RUN;
            FS_FLUSH: begin
                if (drop_cnt_reg == '0) begin
                    state_next = FS_RUN;
                end else if (rsp_ok) begin
                    drop_cnt_next = drop_cnt_reg - CNT_W'(1);
                    if (drop_cnt_reg == CNT_W'(1)) begin
                        state_next = FS_RUN;
                    end
                end
            end
            default: state_next = FS_IDLE;
        endcase
        // Everything still in flight after this cycle, including a request
        // accepted right now, belongs to the old path.
        if (redirect_take) begin
            pc_next       = redirect_target;
            resp_pc_next  = redirect_target;
            drop_cnt_next = outstanding_next;
            state_next    = (outstanding_next == '0) ? FS_RUN : FS_FLUSH;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            misaligned_next = (redirect_pc[1:0] != 2'b00);
`endif
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= FS_IDLE;
            pc_reg          <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_cnt_reg    <= '0;
            hold_reg        <= 1'b0;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            misaligned_reg  <= 1'b0;
`endif
        end else begin
            state_reg       <= state_next;
            pc_reg          <= pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_cnt_reg    <= drop_cnt_next;
            hold_reg        <= hold_next;
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
            misaligned_reg  <= misaligned_next;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with an in-order imem model of
// programmable latency and a queue of expected decode-side {pc, instr}.
module tb_instr_fetch_unit;

    import riscv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_valid, if_ready;
    logic [31:0] if_instr, if_pc;
    logic [6:0]  if_opcode;
    logic        if_misaligned;

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        .if_misaligned  (if_misaligned),
`endif
        .if_opcode      (if_opcode)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          req_cnt = 0;
    int          n_pop   = 0;
    int          due;
    logic [31:0] e;
    pend_t       pend_q[$];
    logic [31:0] exp_q[$];
    logic [31:0] acc_q[$];
    int          pop_cyc[$];

    // Memory contents: opcode cycles through the four constants by word index.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [6:0] opc;
        case (a[3:2])
            2'd0:    opc = OPC_RTYPE;
            2'd1:    opc = OPC_LOAD;
            2'd2:    opc = OPC_STORE;
            default: opc = OPC_BRANCH;
        endcase
        return {a[26:2] ^ 25'h0A5A5A5, opc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    always @(posedge clk) cyc = cyc + 1;

    // imem response driver: in order, one word per cycle when due.
    always @(posedge clk) begin
        #1;
        if (reset) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end else if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q[0].addr);
            void'(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    // Mid-cycle observer: records accepted requests and checks every pop.
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req_valid && imem_req_ready) begin
                due = cyc + lat;
                if (pend_q.size() != 0 && due <= pend_q[$].due) due = pend_q[$].due + 1;
                pend_q.push_back('{imem_req_addr, due});
                acc_q.push_back(imem_req_addr);
                req_cnt++;
            end
            if (if_valid && if_ready) begin
                n_pop++;
                pop_cyc.push_back(cyc);
                n_tests++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL unexpected_pop: observed pc %0h expected none", if_pc);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("if_pc", 64'(if_pc), 64'(e));
                    chk("if_instr", 64'(if_instr), 64'(mem_word(e)));
                    chk("if_opcode", 64'(if_opcode), 64'(mem_word(e) & 32'h7F));
                    $display("[TB] pop pc=%08h instr=%08h opcode=%02h", if_pc, if_instr, if_opcode);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        tick();
        tick();
        exp_q.delete();
        acc_q.delete();
        pop_cyc.delete();
        req_cnt = 0;
        reset   = 1'b0;
    endtask

    task automatic push_seq(input logic [31:0] start, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
        tick();
        redirect_valid = 1'b0;
    endtask

    int p0, r0;

    initial begin
        reset = 1'b1; imem_req_ready = 1'b1; if_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = '0;
        imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset state and first fetch, back-to-back delivery
        lat = 1;
        do_reset();
        chk("rst_req_valid", 64'(imem_req_valid), 64'(0));
        chk("rst_if_valid", 64'(if_valid), 64'(0));
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        chk("rst_misaligned", 64'(if_misaligned), 64'(0));
`endif
        if_ready = 1'b1;
        push_seq(32'h0, 16);
        tick();
        chk("run_req_valid", 64'(imem_req_valid), 64'(1));
        chk("run_req_addr", 64'(imem_req_addr), 64'(0));
        ticks(9);
        if_ready = 1'b0;
        chk("t1_pops_ge4", 64'(pop_cyc.size() >= 4), 64'(1));
        if (pop_cyc.size() >= 4) chk("t1_back_to_back", 64'(pop_cyc[3] - pop_cyc[0]), 64'(3));

        // Decode stalled: credits cap outstanding+buffered at FIFO_DEPTH
        do_reset();
        ticks(10);
        chk("t2_req_count", 64'(req_cnt), 64'(2));
        chk("t2_req_valid_low", 64'(imem_req_valid), 64'(0));
        chk("t2_if_valid", 64'(if_valid), 64'(1));
        p0 = n_pop;
        push_seq(32'h0, 16);
        if_ready = 1'b1;
        ticks(6);
        if_ready = 1'b0;
        chk("t2_drained", 64'(n_pop - p0 >= 4), 64'(1));

        // Redirect with two requests in flight at latency 3
        lat = 3;
        do_reset();
        for (int k = 0; k < 20 && req_cnt < 2; k++) tick();
        chk("t3_two_outstanding", 64'(req_cnt), 64'(2));
        redirect(32'h100);
        exp_q.delete();
        acc_q.delete();
        push_seq(32'h100, 16);
        if_ready = 1'b1;
        r0 = req_cnt;
        chk("t3_if_valid_flushed", 64'(if_valid), 64'(0));
        tick();
        chk("t3_no_req_in_flush", 64'(req_cnt), 64'(r0));
        for (int k = 0; k < 20 && acc_q.size() == 0; k++) tick();
        chk("t3_req_seen", 64'(acc_q.size() != 0), 64'(1));
        if (acc_q.size() != 0) chk("t3_first_addr", 64'(acc_q[0]), 64'(32'h100));
        p0 = n_pop;
        ticks(12);
        if_ready = 1'b0;
        chk("t3_delivered", 64'(n_pop - p0 >= 2), 64'(1));

        // Redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        push_seq(32'h0, 32);
        if_ready = 1'b1;
        for (int k = 0; k < 20 && !(if_valid && imem_rsp_valid); k++) tick();
        chk("t4_setup", 64'(if_valid && imem_rsp_valid), 64'(1));
        redirect(32'h300);
        chk("t4_if_valid_flushed", 64'(if_valid), 64'(0));
        exp_q.delete();
        push_seq(32'h300, 16);
        p0 = n_pop;
        ticks(8);
        if_ready = 1'b0;
        chk("t4_delivered", 64'(n_pop - p0 >= 2), 64'(1));

        // PC wrap at the top of the address space
        do_reset();
        tick();
        redirect(32'hFFFF_FFFC);
        acc_q.delete();
        exp_q.delete();
        exp_q.push_back(32'hFFFF_FFFC);
        push_seq(32'h0, 8);
        if_ready = 1'b1;
        for (int k = 0; k < 20 && acc_q.size() < 2; k++) tick();
        chk("t5_two_reqs", 64'(acc_q.size() >= 2), 64'(1));
        if (acc_q.size() >= 2) begin
            chk("t5_addr_top", 64'(acc_q[0]), 64'(32'hFFFF_FFFC));
            chk("t5_addr_wrap", 64'(acc_q[1]), 64'(0));
        end
        ticks(6);
        if_ready = 1'b0;

        // Misaligned redirect
        do_reset();
        if_ready = 1'b1;
        tick();
        redirect(32'h102);
`ifdef INSTR_FETCH_ALIGN_CHECK_EN
        exp_q.delete();
        chk("t6_misaligned_set", 64'(if_misaligned), 64'(1));
        r0 = req_cnt;
        ticks(10);
        chk("t6_halt_no_req", 64'(req_cnt), 64'(r0));
        chk("t6_halt_if_valid", 64'(if_valid), 64'(0));
        chk("t6_misaligned_sticky", 64'(if_misaligned), 64'(1));
        redirect(32'h200);
        chk("t6_misaligned_clear", 64'(if_misaligned), 64'(0));
        acc_q.delete();
        push_seq(32'h200, 16);
        for (int k = 0; k < 20 && acc_q.size() == 0; k++) tick();
        chk("t6_req_seen", 64'(acc_q.size() != 0), 64'(1));
        if (acc_q.size() != 0) chk("t6_resume_addr", 64'(acc_q[0]), 64'(32'h200));
`else
        exp_q.delete();
        acc_q.delete();
        push_seq(32'h100, 16);
        for (int k = 0; k < 20 && acc_q.size() == 0; k++) tick();
        chk("t6_req_seen", 64'(acc_q.size() != 0), 64'(1));
        if (acc_q.size() != 0) chk("t6_forced_align", 64'(acc_q[0]), 64'(32'h100));
`endif
        p0 = n_pop;
        ticks(8);
        if_ready = 1'b0;
        chk("t6_delivered", 64'(n_pop - p0 >= 2), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
